// File: rtl/os_tile_controller.sv
// Output-stationary tile sequencer for systolic_system: latches a tile config, loads
// ARRAY_N bias words, then steps the array through FLOW, FLUSH, DRAIN_WAIT and STORE.
module os_tile_controller #(
    parameter int unsigned ARRAY_N    = 16,
    parameter int unsigned ARRAY_M    = 16,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned OUT_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [31:0]              cfg_k,
    input  logic [$clog2(ARRAY_N):0] cfg_rows,
    input  logic [$clog2(ARRAY_M):0] cfg_cols,
    input  logic [ADDR_WIDTH-1:0]    cfg_a_base,
    input  logic [ADDR_WIDTH-1:0]    cfg_w_base,
    input  logic [ADDR_WIDTH-1:0]    cfg_o_base,
    input  logic                     bias_valid,
    input  logic [OUT_WIDTH-1:0]     bias_data,
    output logic                     bias_ready,
    output logic                     mode,
    output logic                     a_buf_on,
    output logic                     w_buf_on,
    output logic [ADDR_WIDTH-1:0]    a_base_addr,
    output logic [ADDR_WIDTH-1:0]    w_base_addr,
    output logic [ADDR_WIDTH-1:0]    o_base_addr,
    output logic [$clog2(ARRAY_N):0] a_num_rows,
    output logic [$clog2(ARRAY_M):0] w_num_cols,
    output logic [2:0]               operation_signal_in,
    output logic                     w_en_bias,
    output logic [$clog2(ARRAY_N):0] w_index_bias,
    output logic [OUT_WIDTH-1:0]     w_data_bias,
    output logic                     o_ag_o_on,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err
);

    localparam int unsigned RW = $clog2(ARRAY_N) + 1;
    localparam int unsigned CW = $clog2(ARRAY_M) + 1;
    localparam logic [RW-1:0] ROWS_MAX = RW'(ARRAY_N);
    localparam logic [CW-1:0] COLS_MAX = CW'(ARRAY_M);
    localparam logic [RW-1:0] LAST_IDX = RW'(ARRAY_N - 1);
    localparam logic [2:0] OP_IDLE  = 3'b000;
    localparam logic [2:0] OP_FLOW  = 3'b100;
    localparam logic [2:0] OP_DRAIN = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE, S_BIAS, S_FLOW, S_FLUSH, S_DRAIN, S_STORE, S_DONE
    } state_t;

    state_t                r_state, w_nxt_state;
    logic [31:0]           r_cnt, w_nxt_cnt;
    logic [RW-1:0]         r_bias_idx, w_nxt_idx;
    logic [31:0]           r_k;
    logic [RW-1:0]         r_rows;
    logic [CW-1:0]         r_cols;
    logic [ADDR_WIDTH-1:0] r_a_base, r_w_base, r_o_base;
    logic                  r_bias_ready, r_mode, r_buf_on, r_ag_on, r_busy, r_done, r_cfg_err;
    logic [2:0]            r_op;
    logic                  r_wen;
    logic [RW-1:0]         r_widx;
    logic [OUT_WIDTH-1:0]  r_wdata;

    logic                  w_cfg_ok, w_latch, w_skip_drain;
    logic [31:0]           w_flush_m1, w_drain_m1, w_store_m1;
    logic                  w_nxt_wen, w_nxt_cfg_err;
    logic [RW-1:0]         w_nxt_widx;
    logic [OUT_WIDTH-1:0]  w_nxt_wdata;
    logic [2:0]            w_nxt_op;

    assign w_cfg_ok = (cfg_rows != '0) && (cfg_rows <= ROWS_MAX) &&
                      (cfg_cols != '0) && (cfg_cols <= COLS_MAX) && (cfg_k != 32'd0);

    // Phase lengths minus one; the counter reaches zero in the last cycle of a phase.
    assign w_flush_m1   = 32'(r_rows) + 32'(r_cols) - 32'd2;
    assign w_skip_drain = (32'(r_rows) + 32'd1) >= ARRAY_N;
    assign w_drain_m1   = ARRAY_N - 32'(r_rows) - 32'd2;
    assign w_store_m1   = 32'(r_rows);

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_cnt     = r_cnt;
        w_nxt_idx     = r_bias_idx;
        w_nxt_wen     = 1'b0;
        w_nxt_widx    = r_widx;
        w_nxt_wdata   = r_wdata;
        w_nxt_cfg_err = 1'b0;
        w_latch       = 1'b0;
        w_nxt_op      = OP_IDLE;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_cfg_ok) begin
                        w_nxt_state = S_BIAS;
                        w_nxt_idx   = '0;
                        w_latch     = 1'b1;
                    end else begin
                        w_nxt_cfg_err = 1'b1;
                    end
                end
            end
            S_BIAS: begin
                if (bias_valid) begin
                    w_nxt_wen   = 1'b1;
                    w_nxt_widx  = r_bias_idx;
                    w_nxt_wdata = bias_data;
                    w_nxt_idx   = r_bias_idx + RW'(1);
                    if (r_bias_idx == LAST_IDX) begin
                        w_nxt_state = S_FLOW;
                        w_nxt_cnt   = r_k - 32'd1;
                    end
                end
            end
            S_FLOW: begin
                w_nxt_cnt = r_cnt - 32'd1;
                if (r_cnt == 32'd0) begin
                    w_nxt_state = S_FLUSH;
                    w_nxt_cnt   = w_flush_m1;
                end
            end
            S_FLUSH: begin
                w_nxt_cnt = r_cnt - 32'd1;
                if (r_cnt == 32'd0) begin
                    w_nxt_state = w_skip_drain ? S_STORE : S_DRAIN;
                    w_nxt_cnt   = w_skip_drain ? w_store_m1 : w_drain_m1;
                end
            end
            S_DRAIN: begin
                w_nxt_cnt = r_cnt - 32'd1;
                if (r_cnt == 32'd0) begin
                    w_nxt_state = S_STORE;
                    w_nxt_cnt   = w_store_m1;
                end
            end
            S_STORE: begin
                w_nxt_cnt = r_cnt - 32'd1;
                if (r_cnt == 32'd0) begin
                    w_nxt_state = S_DONE;
                    w_nxt_cnt   = 32'd0;
                end
            end
            S_DONE:  w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase

        // Abort wins over everything the FSM wanted to do this cycle.
        if (abort) begin
            w_nxt_state   = S_IDLE;
            w_nxt_cnt     = 32'd0;
            w_nxt_wen     = 1'b0;
            w_nxt_widx    = '0;
            w_nxt_wdata   = '0;
            w_nxt_cfg_err = 1'b0;
            w_latch       = 1'b0;
        end

        case (w_nxt_state)
            S_FLOW, S_FLUSH:  w_nxt_op = OP_FLOW;
            S_DRAIN, S_STORE: w_nxt_op = OP_DRAIN;
            default:          w_nxt_op = OP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bias_idx   <= '0;
            r_k          <= '0;
            r_rows       <= '0;
            r_cols       <= '0;
            r_a_base     <= '0;
            r_w_base     <= '0;
            r_o_base     <= '0;
            r_bias_ready <= 1'b0;
            r_mode       <= 1'b0;
            r_buf_on     <= 1'b0;
            r_ag_on      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_op         <= OP_IDLE;
            r_wen        <= 1'b0;
            r_widx       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state      <= w_nxt_state;
            r_cnt        <= w_nxt_cnt;
            r_bias_idx   <= w_nxt_idx;
            r_bias_ready <= (w_nxt_state == S_BIAS);
            r_mode       <= (w_nxt_state != S_IDLE);
            r_busy       <= (w_nxt_state != S_IDLE);
            r_buf_on     <= (w_nxt_state == S_FLOW);
            r_ag_on      <= (w_nxt_state == S_STORE);
            r_done       <= (w_nxt_state == S_DONE);
            r_cfg_err    <= w_nxt_cfg_err;
            r_op         <= w_nxt_op;
            r_wen        <= w_nxt_wen;
            r_widx       <= w_nxt_widx;
            r_wdata      <= w_nxt_wdata;
            if (abort) begin
                r_k      <= '0;
                r_rows   <= '0;
                r_cols   <= '0;
                r_a_base <= '0;
                r_w_base <= '0;
                r_o_base <= '0;
            end else if (w_latch) begin
                r_k      <= cfg_k;
                r_rows   <= cfg_rows;
                r_cols   <= cfg_cols;
                r_a_base <= cfg_a_base;
                r_w_base <= cfg_w_base;
                r_o_base <= cfg_o_base;
            end
        end
    end

    assign bias_ready          = r_bias_ready;
    assign mode                = r_mode;
    assign a_buf_on            = r_buf_on;
    assign w_buf_on            = r_buf_on;
    assign a_base_addr         = r_a_base;
    assign w_base_addr         = r_w_base;
    assign o_base_addr         = r_o_base;
    assign a_num_rows          = r_rows;
    assign w_num_cols          = r_cols;
    assign operation_signal_in = r_op;
    assign w_en_bias           = r_wen;
    assign w_index_bias        = r_widx;
    assign w_data_bias         = r_wdata;
    assign o_ag_o_on           = r_ag_on;
    assign busy                = r_busy;
    assign done                = r_done;
    assign cfg_err             = r_cfg_err;

endmodule

// File: tb/tb_os_tile_controller.sv
// Directed bench for os_tile_controller: bias load, phase lengths, config rejection,
// abort, reset mid-tile and start-while-busy. Cycle 0 is the cycle in which start is high.
module tb_os_tile_controller;

    logic        clk, reset, start, abort, bias_valid;
    logic [31:0] cfg_k, bias_data;
    logic [4:0]  cfg_rows, cfg_cols;
    logic [9:0]  cfg_a_base, cfg_w_base, cfg_o_base;
    logic        bias_ready, mode, a_buf_on, w_buf_on, w_en_bias, o_ag_o_on, busy, done, cfg_err;
    logic [9:0]  a_base_addr, w_base_addr, o_base_addr;
    logic [4:0]  a_num_rows, w_num_cols, w_index_bias;
    logic [2:0]  operation_signal_in;
    logic [31:0] w_data_bias;

    int n_assert = 0;
    int n_fail   = 0;

    int wr_cnt, idx_err, data_err, flow_n, flush_n, drain_n, store_n, op_err;
    int done_cyc, first_flow, last_wr_cyc, sent;
    logic [9:0] cap_a, cap_w, cap_o;
    logic [4:0] cap_rows, cap_cols;

    os_tile_controller dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_k(cfg_k), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .cfg_a_base(cfg_a_base), .cfg_w_base(cfg_w_base), .cfg_o_base(cfg_o_base),
        .bias_valid(bias_valid), .bias_data(bias_data), .bias_ready(bias_ready),
        .mode(mode), .a_buf_on(a_buf_on), .w_buf_on(w_buf_on),
        .a_base_addr(a_base_addr), .w_base_addr(w_base_addr), .o_base_addr(o_base_addr),
        .a_num_rows(a_num_rows), .w_num_cols(w_num_cols),
        .operation_signal_in(operation_signal_in), .w_en_bias(w_en_bias),
        .w_index_bias(w_index_bias), .w_data_bias(w_data_bias), .o_ag_o_on(o_ag_o_on),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic all_out_or();
        return |{bias_ready, mode, a_buf_on, w_buf_on, a_base_addr, w_base_addr, o_base_addr,
                 a_num_rows, w_num_cols, operation_signal_in, w_en_bias, w_index_bias,
                 w_data_bias, o_ag_o_on, busy, done, cfg_err};
    endfunction

    function automatic logic ctrl_or();
        return |{bias_ready, mode, a_buf_on, w_buf_on, operation_signal_in, w_en_bias,
                 o_ag_o_on, busy, done};
    endfunction

    task automatic start_tile(input logic [4:0] rows, input logic [4:0] cols, input logic [31:0] k,
                              input logic [9:0] ab, input logic [9:0] wb, input logic [9:0] ob);
        cfg_rows = rows; cfg_cols = cols; cfg_k = k;
        cfg_a_base = ab; cfg_w_base = wb; cfg_o_base = ob;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Walks a tile cycle by cycle from cycle 1, feeding bias words and tallying what is observed.
    task automatic run_tile(input bit toggle, input logic [31:0] dbase, input bit tag_idx,
                            input int abort_at, input int mid_start_at, input int reset_at);
        bit stop;
        wr_cnt = 0; idx_err = 0; data_err = 0; flow_n = 0; flush_n = 0; drain_n = 0;
        store_n = 0; op_err = 0; done_cyc = -1; first_flow = -1; last_wr_cyc = -1; sent = 0;
        stop = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (w_en_bias) begin
                if (w_index_bias !== 5'(wr_cnt)) idx_err++;
                if (w_data_bias !== (tag_idx ? dbase + 32'(wr_cnt) : dbase)) data_err++;
                wr_cnt++;
                last_wr_cyc = c;
            end
            if (a_buf_on) begin
                if (first_flow < 0) first_flow = c;
                flow_n++;
                if (operation_signal_in !== 3'b100 || w_buf_on !== 1'b1) op_err++;
            end else if (operation_signal_in === 3'b100) begin
                flush_n++;
            end else if (operation_signal_in === 3'b110 && o_ag_o_on === 1'b0) begin
                drain_n++;
            end
            if (o_ag_o_on) begin
                store_n++;
                if (operation_signal_in !== 3'b110) op_err++;
            end
            if (busy !== 1'b1 || mode !== 1'b1) op_err++;
            if (done === 1'b1) begin
                if (operation_signal_in !== 3'b000) op_err++;
                done_cyc = c;
                break;
            end
            start = 1'b0;
            abort = 1'b0;
            if (abort_at > 0 && a_buf_on && flow_n == abort_at) begin
                abort = 1'b1;
                stop  = 1'b1;
            end
            if (mid_start_at > 0 && a_buf_on && flow_n == mid_start_at) begin
                start = 1'b1;
                cfg_rows = 5'd3; cfg_cols = 5'd3; cfg_k = 32'd4;
                cfg_a_base = 10'h001; cfg_w_base = 10'h002; cfg_o_base = 10'h003;
            end
            if (reset_at > 0 && o_ag_o_on && store_n == reset_at) begin
                cap_a = a_base_addr; cap_w = w_base_addr; cap_o = o_base_addr;
                cap_rows = a_num_rows; cap_cols = w_num_cols;
                reset = 1'b1;
                stop  = 1'b1;
            end
            bias_valid = bias_ready && (!toggle || (c % 2 == 1));
            bias_data  = tag_idx ? dbase + 32'(sent) : dbase;
            if (bias_valid) sent++;
            step();
            if (stop) begin
                abort = 1'b0;
                reset = 1'b0;
                break;
            end
        end
        bias_valid = 1'b0;
        start      = 1'b0;
    endtask

    initial begin
        int n_done;
        reset = 1'b1; start = 1'b0; abort = 1'b0; bias_valid = 1'b0; bias_data = '0;
        cfg_k = '0; cfg_rows = '0; cfg_cols = '0;
        cfg_a_base = '0; cfg_w_base = '0; cfg_o_base = '0;

        // Reset state
        @(negedge clk);
        chk("reset_outputs", 32'(all_out_or()), 32'd0);
        step(); step();
        reset = 1'b0;
        step();
        chk("post_reset_outputs", 32'(all_out_or()), 32'd0);

        // T1: 10x10 tile, K=30, bias every cycle
        start_tile(5'd10, 5'd10, 32'd30, 10'h011, 10'h022, 10'h033);
        chk("t1_bias_ready", 32'(bias_ready), 32'd1);
        chk("t1_mode", 32'(mode), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_addrs", 32'({a_base_addr, w_base_addr, o_base_addr}), 32'({10'h011, 10'h022, 10'h033}));
        chk("t1_dims", 32'({a_num_rows, w_num_cols}), 32'({5'd10, 5'd10}));
        run_tile(1'b0, 32'hFFFF_FFF0, 1'b0, 0, 0, 0);
        chk("t1_bias_writes", 32'(wr_cnt), 32'd16);
        chk("t1_bias_idx_order", 32'(idx_err), 32'd0);
        chk("t1_bias_data", 32'(data_err), 32'd0);
        chk("t1_first_flow", 32'(first_flow), 32'd17);
        chk("t1_flow_len", 32'(flow_n), 32'd30);
        chk("t1_flush_len", 32'(flush_n), 32'd19);
        chk("t1_drain_len", 32'(drain_n), 32'd5);
        chk("t1_store_len", 32'(store_n), 32'd11);
        chk("t1_ctrl_consistency", 32'(op_err), 32'd0);
        chk("t1_done_cycle", 32'(done_cyc), 32'd82);
        step();
        chk("t1_idle_after_done", 32'({busy, mode, done, operation_signal_in}), 32'd0);

        // T2: full 16x16 tile, K=1, DRAIN_WAIT skipped
        start_tile(5'd16, 5'd16, 32'd1, 10'h100, 10'h200, 10'h300);
        run_tile(1'b0, 32'h0000_A000, 1'b1, 0, 0, 0);
        chk("t2_bias_data", 32'(data_err), 32'd0);
        chk("t2_flow_len", 32'(flow_n), 32'd1);
        chk("t2_flush_len", 32'(flush_n), 32'd31);
        chk("t2_drain_len", 32'(drain_n), 32'd0);
        chk("t2_store_len", 32'(store_n), 32'd17);
        chk("t2_done_cycle", 32'(done_cyc), 32'd66);
        step();

        // rows = ARRAY_N-1 also skips DRAIN_WAIT
        start_tile(5'd15, 5'd1, 32'd2, 10'h005, 10'h006, 10'h007);
        run_tile(1'b0, 32'h1234_5678, 1'b0, 0, 0, 0);
        chk("t2b_flush_len", 32'(flush_n), 32'd15);
        chk("t2b_drain_len", 32'(drain_n), 32'd0);
        chk("t2b_store_len", 32'(store_n), 32'd16);
        chk("t2b_done_cycle", 32'(done_cyc), 32'd50);
        step();

        // T3: rejected configurations
        start_tile(5'd0, 5'd5, 32'd3, 10'h0AA, 10'h0BB, 10'h0CC);
        chk("t3_rows0_cfg_err", 32'(cfg_err), 32'd1);
        chk("t3_rows0_ctrl", 32'(ctrl_or()), 32'd0);
        step();
        chk("t3_cfg_err_pulse", 32'(cfg_err), 32'd0);
        start_tile(5'd4, 5'd17, 32'd3, 10'h0AA, 10'h0BB, 10'h0CC);
        chk("t3_cols17_cfg_err", 32'(cfg_err), 32'd1);
        chk("t3_cols17_ctrl", 32'(ctrl_or()), 32'd0);
        step();
        start_tile(5'd4, 5'd4, 32'd0, 10'h0AA, 10'h0BB, 10'h0CC);
        chk("t3_k0_cfg_err", 32'(cfg_err), 32'd1);
        chk("t3_k0_ctrl", 32'(ctrl_or()), 32'd0);
        step();
        start_tile(5'd17, 5'd4, 32'd2, 10'h0AA, 10'h0BB, 10'h0CC);
        chk("t3_rows17_cfg_err", 32'(cfg_err), 32'd1);
        chk("t3_rows17_busy", 32'(busy), 32'd0);
        step();

        // T4: bias_valid toggling 1,0,1,0
        start_tile(5'd4, 5'd6, 32'd5, 10'h044, 10'h055, 10'h066);
        run_tile(1'b1, 32'h0000_1000, 1'b1, 0, 0, 0);
        chk("t4_bias_writes", 32'(wr_cnt), 32'd16);
        chk("t4_bias_idx_order", 32'(idx_err), 32'd0);
        chk("t4_bias_data", 32'(data_err), 32'd0);
        chk("t4_last_write_cycle", 32'(last_wr_cyc), 32'd32);
        chk("t4_flow_with_last_write", 32'(first_flow), 32'(last_wr_cyc));
        chk("t4_flush_len", 32'(flush_n), 32'd9);
        chk("t4_drain_len", 32'(drain_n), 32'd11);
        chk("t4_done_cycle", 32'(done_cyc), 32'd62);
        step();

        // T5: abort in FLOW cycle 12, then a normal tile
        start_tile(5'd10, 5'd10, 32'd30, 10'h011, 10'h022, 10'h033);
        run_tile(1'b0, 32'hFFFF_FFF0, 1'b0, 12, 0, 0);
        chk("t5_abort_flow_count", 32'(flow_n), 32'd12);
        chk("t5_abort_op", 32'(operation_signal_in), 32'd0);
        chk("t5_abort_bufs", 32'({a_buf_on, w_buf_on}), 32'd0);
        chk("t5_abort_busy", 32'({busy, mode}), 32'd0);
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) n_done++;
            step();
        end
        chk("t5_no_done_after_abort", 32'(n_done), 32'd0);
        start_tile(5'd8, 5'd12, 32'd7, 10'h0F0, 10'h0F1, 10'h0F2);
        run_tile(1'b0, 32'h0BAD_0000, 1'b1, 0, 0, 0);
        chk("t5_second_flush", 32'(flush_n), 32'd19);
        chk("t5_second_drain", 32'(drain_n), 32'd7);
        chk("t5_second_store", 32'(store_n), 32'd9);
        chk("t5_second_done_cycle", 32'(done_cyc), 32'd59);
        step();

        // T6: start while busy ignored, reset during STORE
        start_tile(5'd6, 5'd5, 32'd9, 10'h155, 10'h2AA, 10'h3C3);
        run_tile(1'b0, 32'h0000_0042, 1'b0, 0, 5, 3);
        chk("t6_flow_len", 32'(flow_n), 32'd9);
        chk("t6_flush_len", 32'(flush_n), 32'd10);
        chk("t6_drain_len", 32'(drain_n), 32'd9);
        chk("t6_addrs_held", 32'({cap_a, cap_w, cap_o}), 32'({10'h155, 10'h2AA, 10'h3C3}));
        chk("t6_dims_held", 32'({cap_rows, cap_cols}), 32'({5'd6, 5'd5}));
        chk("t6_reset_outputs", 32'(all_out_or()), 32'd0);
        chk("t6_no_done", 32'(done_cyc < 0), 32'd1);
        step();
        chk("t6_idle_after_reset", 32'({busy, done, cfg_err}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
